// File: rtl/reorder_pkg.sv
// Shared types and sizing for the image reordering engine's hash loader.
package reorder_pkg;
  localparam int HASH_W         = 256;
  localparam int WORD_W         = 32;
  localparam int IDX_W          = 16;
  localparam int WORDS_PER_HASH = HASH_W / WORD_W;
  localparam int WCNT_W         = (WORDS_PER_HASH > 1) ? $clog2(WORDS_PER_HASH) : 1;

  typedef logic [HASH_W-1:0] hash_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [WCNT_W-1:0] wcnt_t;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} ld_state_e;
endpackage

// File: rtl/hash_loader_if.sv
// Word stream in and hash memory write port out of the hash loader.
interface hash_loader_if;
  import reorder_pkg::*;

  logic  s_valid;
  logic  s_ready;
  word_t s_data;
  logic  wr_en;
  idx_t  wr_addr;
  hash_t wr_data;

  modport master (output s_valid, s_data, input s_ready, wr_en, wr_addr, wr_data);
  modport slave  (input s_valid, s_data, output s_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/hash_word_assembler.sv
// Collects WORDS_PER_HASH words into one hash; full_o pulses with the last word.
module hash_word_assembler
  import reorder_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clr_i,
  input  logic  acc_i,
  input  word_t word_i,
  output logic  full_o,
  output hash_t hash_o
);
  localparam wcnt_t LAST = wcnt_t'(WORDS_PER_HASH - 1);

  wcnt_t cnt_q, cnt_d;
  hash_t hash_q, hash_d;

  assign full_o = acc_i && (cnt_q == LAST);
  assign hash_o = hash_q;

  // Words shift in from the top, so word 0 lands in the low slice after the last shift.
  always_comb begin
    cnt_d  = cnt_q;
    hash_d = hash_q;
    if (clr_i) begin
      cnt_d  = '0;
      hash_d = '0;
    end else if (acc_i) begin
      hash_d = {word_i, hash_q[HASH_W-1:WORD_W]};
      cnt_d  = full_o ? '0 : cnt_q + wcnt_t'(1);
    end
  end

  // Word counter and assembly register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      hash_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hash_q <= hash_d;
    end
  end
endmodule

// File: rtl/hash_loader.sv
// Hash loader: assembles 32-bit words into hashes and writes them to the
// hash memory at indices 0..num_images-1, then raises load_done.
// Optional running XOR checksum of accepted words: HASH_LOADER_CKSUM_EN.
module hash_loader
  import reorder_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  idx_t         num_images_in,
  hash_loader_if.slave bus,
  output idx_t         num_images,
  output logic         load_done,
  output logic         busy,
  output word_t        cksum
);
  ld_state_e state_q, state_d;
  idx_t      num_q, img_q, img_d, wr_addr_q;
  hash_t     wr_data_q, asm_hash;
  logic      accept, full, wr_fire, last_img;

  // start wins over a same-cycle handshake and over a pending write.
  assign bus.s_ready = (state_q == COLLECT);
  assign accept      = bus.s_valid && bus.s_ready && !start;
  assign wr_fire     = (state_q == WRITE) && !start;
  assign last_img    = (img_q == num_q - idx_t'(1));

  hash_word_assembler u_asm (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (start),
    .acc_i  (accept),
    .word_i (bus.s_data),
    .full_o (full),
    .hash_o (asm_hash)
  );

  // Next-state logic; start restarts the session from any state.
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    if (start) begin
      state_d = (num_images_in == '0) ? DONE : COLLECT;
      img_d   = '0;
    end else begin
      case (state_q)
        COLLECT: if (full) state_d = WRITE;
        WRITE: begin
          if (last_img) begin
            state_d = DONE;
          end else begin
            state_d = COLLECT;
            img_d   = img_q + idx_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Image counter, latched count and the held copy of the last write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      img_q     <= '0;
      num_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      img_q <= img_d;
      if (start) num_q <= num_images_in;
      if (wr_fire) begin
        wr_addr_q <= img_q;
        wr_data_q <= asm_hash;
      end
    end
  end

  // Write port shows live values only on the strobe, so an aborted write leaves it untouched.
  assign bus.wr_en   = wr_fire;
  assign bus.wr_addr = wr_fire ? img_q : wr_addr_q;
  assign bus.wr_data = wr_fire ? asm_hash : wr_data_q;

  assign num_images = num_q;
  assign load_done  = (state_q == DONE);
  assign busy       = (state_q == COLLECT) || (state_q == WRITE);

`ifdef HASH_LOADER_CKSUM_EN
  word_t cksum_q;

  // XOR of every word accepted since the last start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cksum_q <= '0;
    else if (start)  cksum_q <= '0;
    else if (accept) cksum_q <= cksum_q ^ bus.s_data;
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif
endmodule

// File: tb/tb_hash_loader.sv
// Self-checking bench for hash_loader: table of load sessions plus
// hand-written reset, zero-count, abort and checksum sequences.
`timescale 1ns/1ps
module tb_hash_loader;
  import reorder_pkg::*;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  logic  start = 1'b0;
  idx_t  num_images_in = '0;
  idx_t  num_images;
  logic  load_done, busy;
  word_t cksum;

  hash_loader_if bus();

  hash_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_images_in (num_images_in),
    .bus           (bus),
    .num_images    (num_images),
    .load_done     (load_done),
    .busy          (busy),
    .cksum         (cksum)
  );

  always #5 clk = ~clk;

  typedef struct { idx_t addr; hash_t data; } exp_wr_t;
  typedef struct { int num; bit gaps; int exp_lat; } vec_t;

  exp_wr_t exp_q[$];
  int      checks = 0, failures = 0, n_wr = 0, cyc = 0, s0 = 0;
  hash_t   H[5];
  word_t   ck_model = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [HASH_W-1:0] got, input logic [HASH_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic word_t exp_ck(input word_t m);
`ifdef HASH_LOADER_CKSUM_EN
    return m;
`else
    return '0;
`endif
  endfunction

  // Scoreboard: every write strobe pops one expected {addr, data}.
  always @(negedge clk) begin : mon
    exp_wr_t e;
    if (reset && bus.wr_en === 1'b1) begin
      n_wr++;
      chk("wr_ready_low", HASH_W'(bus.s_ready), '0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected addr=%0d data=%0h", bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", HASH_W'(bus.wr_addr), HASH_W'(e.addr));
        chk("wr_data", bus.wr_data, e.data);
      end
    end
  end

  task automatic chk_zero(input string p);
    chk({p, "_s_ready"},   HASH_W'(bus.s_ready), '0);
    chk({p, "_wr_en"},     HASH_W'(bus.wr_en), '0);
    chk({p, "_wr_addr"},   HASH_W'(bus.wr_addr), '0);
    chk({p, "_wr_data"},   bus.wr_data, '0);
    chk({p, "_num"},       HASH_W'(num_images), '0);
    chk({p, "_load_done"}, HASH_W'(load_done), '0);
    chk({p, "_busy"},      HASH_W'(busy), '0);
    chk({p, "_cksum"},     HASH_W'(cksum), '0);
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_images_in = idx_t'(n);
    @(posedge clk); #1;
    start = 1'b0;
    ck_model = '0;
    s0 = cyc;
  endtask

  task automatic send_word(input word_t w, input bit gaps);
    int t;
    if (gaps)
      for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      if (bus.s_ready) break;
      t++;
    end
    if (t >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout word=%0h", w);
    end else begin
      ck_model ^= w;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic send_hash(input int idx, input hash_t h, input bit gaps);
    exp_wr_t e;
    e.addr = idx_t'(idx);
    e.data = h;
    exp_q.push_back(e);
    for (int k = 0; k < WORDS_PER_HASH; k++) send_word(h[k*WORD_W +: WORD_W], gaps);
  endtask

  task automatic wait_done(output int lat);
    int t;
    t = 0;
    while (t < 2000) begin
      @(negedge clk);
      if (load_done) break;
      t++;
    end
    lat = cyc - s0;
    if (t >= 2000) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=0 exp=1");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[5];
    int    lat, n0;
    hash_t hc;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    H[0] = 256'h1;
    H[1] = {{7{32'h1111_1111}}, 32'h0000_0011};
    H[2] = {{7{32'h1111_1111}}, 32'h0000_0111};
    H[3] = {32'h0000_1111, {7{32'h1111_1111}}};
    H[4] = {32'h0000_1111, {6{32'h1111_1111}}, 32'h0000_0000};
    tbl[0] = '{5, 1'b0, 45};
    tbl[1] = '{5, 1'b1, -1};
    tbl[2] = '{1, 1'b0, 9};
    tbl[3] = '{3, 1'b1, -1};
    tbl[4] = '{2, 1'b0, 18};

    // Reset state.
    #12;
    chk_zero("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a session clears everything at once.
    do_start(5);
    send_hash(0, H[0], 1'b0);
    for (int k = 0; k < 4; k++) send_word(H[1][k*WORD_W +: WORD_W], 1'b0);
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    chk("midrst_q", HASH_W'(exp_q.size()), '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Table of load sessions (each restarts from the previous DONE).
    for (int r = 0; r < 5; r++) begin
      n0 = n_wr;
      do_start(tbl[r].num);
      chk("row_done_clr", HASH_W'(load_done), '0);
      chk("row_busy", HASH_W'(busy), 256'h1);
      for (int i = 0; i < tbl[r].num; i++) send_hash(i, H[i], tbl[r].gaps);
      wait_done(lat);
      if (tbl[r].exp_lat >= 0) chk("row_latency", HASH_W'(lat), HASH_W'(tbl[r].exp_lat));
      chk("row_num", HASH_W'(num_images), HASH_W'(tbl[r].num));
      chk("row_nwr", HASH_W'(n_wr - n0), HASH_W'(tbl[r].num));
      chk("row_q_empty", HASH_W'(exp_q.size()), '0);
      chk("row_hold_addr", HASH_W'(bus.wr_addr), HASH_W'(tbl[r].num - 1));
      chk("row_hold_data", bus.wr_data, H[tbl[r].num - 1]);
      chk("row_cksum", HASH_W'(cksum), HASH_W'(exp_ck(ck_model)));
      chk("row_idle_busy", HASH_W'(busy), '0);
    end

    // Words offered in DONE are not consumed.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_ready", HASH_W'(bus.s_ready), '0);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    chk("done_cksum_stable", HASH_W'(cksum), HASH_W'(exp_ck(ck_model)));
    chk("done_still", HASH_W'(load_done), 256'h1);

    // Zero images: done immediately, never busy, no writes.
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    n0 = n_wr;
    do_start(0);
    chk("zero_done", HASH_W'(load_done), 256'h1);
    chk("zero_num", HASH_W'(num_images), '0);
    for (int i = 0; i < 5; i++) begin
      chk("zero_busy", HASH_W'(busy), '0);
      @(posedge clk); #1;
    end
    chk("zero_nwr", HASH_W'(n_wr - n0), '0);

    // Abort at image 2, word 3; the word offered with start is dropped.
    n0 = n_wr;
    do_start(3);
    send_hash(0, H[0], 1'b0);
    send_hash(1, H[1], 1'b0);
    for (int k = 0; k < 3; k++) send_word(H[2][k*WORD_W +: WORD_W], 1'b0);
    start = 1'b1;
    num_images_in = 16'd3;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    bus.s_valid = 1'b0;
    ck_model = '0;
    s0 = cyc;
    chk("abort_nwr", HASH_W'(n_wr - n0), 256'h2);
    chk("abort_busy", HASH_W'(busy), 256'h1);
    send_hash(0, H[2], 1'b0);
    send_hash(1, H[3], 1'b1);
    send_hash(2, H[4], 1'b0);
    wait_done(lat);
    chk("abort_total_nwr", HASH_W'(n_wr - n0), 256'h5);
    chk("abort_q_empty", HASH_W'(exp_q.size()), '0);
    chk("abort_cksum", HASH_W'(cksum), HASH_W'(exp_ck(ck_model)));

    // start during WRITE suppresses that write.
    n0 = n_wr;
    do_start(2);
    for (int k = 0; k < WORDS_PER_HASH; k++) send_word(H[0][k*WORD_W +: WORD_W], 1'b0);
    do_start(1);
    chk("wabort_nwr", HASH_W'(n_wr - n0), '0);
    send_hash(0, H[1], 1'b0);
    wait_done(lat);
    chk("wabort_total_nwr", HASH_W'(n_wr - n0), 256'h1);
    chk("wabort_num", HASH_W'(num_images), 256'h1);

    // Checksum of words 1..8 for a single image.
    for (int k = 0; k < WORDS_PER_HASH; k++) hc[k*WORD_W +: WORD_W] = word_t'(k + 1);
    do_start(1);
    send_hash(0, hc, 1'b0);
    wait_done(lat);
`ifdef HASH_LOADER_CKSUM_EN
    chk("cksum_1to8", HASH_W'(cksum), 256'h8);
`else
    chk("cksum_off", HASH_W'(cksum), '0);
`endif
    chk("cksum_q_empty", HASH_W'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hash_loader.md
Name: hash_loader

Overview:
- Write-side front end for the image reordering engine.
- Accepts per-image 256-bit perceptual hashes as a stream of 32-bit words over a valid/ready handshake.
- Assembles each hash and writes it into the engine's hash memory at consecutive indices 0..num_images-1.
- Signals load completion together with the image count, so the reordering engine can start reading.

Parameters:
- HASH_W, 256, hash width in bits.
- WORD_W, 32, input word width; HASH_W must be an integer multiple of WORD_W.
- IDX_W, 16, image index and count width (max 65535 images).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session.
- num_images_in  in  IDX_W  image count, sampled on start.
- s_valid  in  1  input word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  WORD_W  hash word, least-significant word first.
- wr_en  out  1  hash memory write strobe.
- wr_addr  out  IDX_W  image index being written.
- wr_data  out  HASH_W  assembled hash.
- num_images  out  IDX_W  latched count, valid while load_done=1.
- load_done  out  1  level; set when all hashes are written, cleared by start or reset.
- busy  out  1  high in COLLECT or WRITE.
- cksum  out  WORD_W  running XOR of accepted words (see Optional Feature).

Behaviour:
- Reset (reset=0, async): state=IDLE. s_ready=0, wr_en=0, wr_addr=0, wr_data=0, num_images=0, load_done=0, busy=0, cksum=0. Word counter=0, image counter=0.
- WPH = HASH_W/WORD_W = 8 words per hash.
- A word is accepted when s_valid & s_ready are both high at a rising edge.
  - Word k of a hash goes to bits [k*WORD_W +: WORD_W].
- States:
  - IDLE: s_ready=0. On start: latch num_images_in, clear counters, clear load_done. Go to DONE if num_images_in==0, else COLLECT.
  - COLLECT: s_ready=1. Each accepted word fills the shift/assembly register and increments the word counter. On the 8th accepted word, go to WRITE.
  - WRITE (exactly one cycle): s_ready=0, wr_en=1, wr_addr=image counter, wr_data=assembled hash.
    - Next state is DONE if image counter==num_images-1.
    - Otherwise increment the image counter, clear the word counter, and return to COLLECT.
  - DONE: load_done=1, num_images=latched count, s_ready=0. Words offered here are ignored, not consumed. On start, behave as IDLE on start.
- Latency: wr_en is asserted the cycle after the 8th handshake of each hash. load_done rises the cycle after the last WRITE.
- Sustained throughput: 8 words per 9 cycles.
- start in COLLECT or WRITE aborts the session. The partial hash is discarded, no write occurs in that cycle, and the new count is latched. start has priority over a same-cycle handshake; that word is dropped.
- wr_addr and wr_data hold their last values outside WRITE. wr_en is only ever a single-cycle pulse.
- Counters are IDX_W wide. num_images_in=65535 must complete without wrap. The image counter never exceeds num_images-1.

Optional Feature:
- Macro: HASH_LOADER_CKSUM_EN.
- When defined:
  - cksum is the XOR of every word accepted since the last start; it is cleared on start and on reset.
  - cksum is stable and final while load_done=1.
- When undefined:
  - The cksum port is still present but is tied to 0.
  - No checksum register is synthesized.

Decomposition:
- Shared package reorder_pkg holds:
  - HASH_W, WORD_W, IDX_W.
  - WORDS_PER_HASH.
  - typedefs hash_t (logic [HASH_W-1:0]) and idx_t (logic [IDX_W-1:0]).
  - the loader state enum (IDLE, COLLECT, WRITE, DONE).
- One natural sub-module, hash_word_assembler: a word counter plus assembly register that pulses full after WPH words and clears on abort.

Test Plan:
- Reset mid-session: deassert reset, start with num_images_in=5, send 12 words, pulse reset low → all outputs 0 at once. After release and a new start, a full 5-image load completes normally.
- num_images_in=5, hashes 0x...0001, 0x1111...0011, 0x1111...0111, 0x0000_1111...1111, 0x0000_1111...0000, s_valid held high → 5 wr_en pulses at addr 0..4 with matching wr_data. load_done=1 and num_images=5 after 45 cycles of COLLECT/WRITE.
- Random s_valid gaps (50% duty), same 5 hashes → identical memory contents. s_ready stays 0 during every WRITE cycle.
- start with num_images_in=0 → load_done=1 the next cycle, no wr_en, busy never high.
- start at image 2, word 3, with num_images_in=3 → no partial write. Next writes restart at addr 0. load_done after 3 writes.
- With HASH_LOADER_CKSUM_EN defined, 1 image with words 0x1,0x2,...,0x8 → cksum=0x8 at load_done. Without the macro → cksum=0 throughout.
